// File: rtl/contador_mod_param.sv
// Parametrised modulo counter for the RTC chain: enable, up/down, clamped load,
// registered wrap/borrow cascade pulses and a registered two-digit BCD view of the count.
module contador_mod_param #(
  parameter int WIDTH   = 5,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 23
) (
  input  logic             clk,
  input  logic             reset_clk,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] conta,
  output logic             wrap,
  output logic             borrow,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  // Binary 0..99 to {tens, units}: nine conditional subtract-10 passes, no divider.
  function automatic logic [7:0] to_bcd(input logic [6:0] value);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = value;
    tens = 4'd0;
    for (int i = 32'sd0; i < 32'sd9; i++) begin
      tens = (rem >= 7'd10) ? tens + 4'd1 : tens;
      rem  = (rem >= 7'd10) ? rem - 7'd10 : rem;
    end
    return {tens, rem[3:0]};
  endfunction

  localparam logic [7:0] RST_BCD = to_bcd(7'(MIN_VAL));

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             borrow_next;
  logic [7:0]       bcd_next;
  logic             in_range;

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    count_next  = conta;
    wrap_next   = 1'b0;
    borrow_next = 1'b0;
    in_range    = (conta >= MIN_W) && (conta <= MAX_W);
    if (load) begin
      if (load_val < MIN_W) begin
        count_next = MIN_W;
      end else if (load_val > MAX_W) begin
        count_next = MAX_W;
      end else begin
        count_next = load_val;
      end
    end else if (en) begin
      if (up_down) begin
        if (!in_range) begin
          count_next = MIN_W;
        end else if (conta == MAX_W) begin
          count_next = MIN_W;
          wrap_next  = 1'b1;
        end else begin
          count_next = conta + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        if (!in_range) begin
          count_next = MAX_W;
        end else if (conta == MIN_W) begin
          count_next  = MAX_W;
          borrow_next = 1'b1;
        end else begin
          count_next = conta - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      count_next = conta;
    end
    bcd_next = to_bcd(7'(count_next));
  end

  // State and output registers; BCD is taken from the next count so it never lags conta.
  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk) begin
      conta     <= MIN_W;
      wrap      <= 1'b0;
      borrow    <= 1'b0;
      bcd_tens  <= RST_BCD[7:4];
      bcd_units <= RST_BCD[3:0];
    end else begin
      conta     <= count_next;
      wrap      <= wrap_next;
      borrow    <= borrow_next;
      bcd_tens  <= bcd_next[7:4];
      bcd_units <= bcd_next[3:0];
    end
  end

endmodule

// File: tb/tb_contador_mod_param.sv
// Directed bench for contador_mod_param: default 0..23 counter, a 1..12 counter,
// and a 0..59 -> 0..23 cascade, all sharing clk and reset_clk.
module tb_contador_mod_param;

  logic clk = 1'b0;
  logic reset_clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: defaults 0..23
  logic       en_a = 1'b0, ud_a = 1'b1, load_a = 1'b0;
  logic [4:0] lv_a = 5'd0, conta_a;
  logic       wrap_a, borrow_a;
  logic [3:0] tens_a, units_a;

  contador_mod_param u_dut (
    .clk(clk), .reset_clk(reset_clk), .en(en_a), .up_down(ud_a), .load(load_a),
    .load_val(lv_a), .conta(conta_a), .wrap(wrap_a), .borrow(borrow_a),
    .bcd_tens(tens_a), .bcd_units(units_a)
  );

  // Instance B: 1..12
  logic       en_b = 1'b0, ud_b = 1'b1, load_b = 1'b0;
  logic [3:0] lv_b = 4'd0, conta_b;
  logic       wrap_b, borrow_b;
  logic [3:0] tens_b, units_b;

  contador_mod_param #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12)) u_m12 (
    .clk(clk), .reset_clk(reset_clk), .en(en_b), .up_down(ud_b), .load(load_b),
    .load_val(lv_b), .conta(conta_b), .wrap(wrap_b), .borrow(borrow_b),
    .bcd_tens(tens_b), .bcd_units(units_b)
  );

  // Cascade: minutes 0..59 feed hours 0..23
  logic       en_c = 1'b0;
  logic [5:0] conta_min;
  logic       wrap_min, borrow_min;
  logic [3:0] tens_min, units_min;
  logic [4:0] conta_hr;
  logic       wrap_hr, borrow_hr;
  logic [3:0] tens_hr, units_hr;

  contador_mod_param #(.WIDTH(6), .MIN_VAL(0), .MAX_VAL(59)) u_min (
    .clk(clk), .reset_clk(reset_clk), .en(en_c), .up_down(1'b1), .load(1'b0),
    .load_val(6'd0), .conta(conta_min), .wrap(wrap_min), .borrow(borrow_min),
    .bcd_tens(tens_min), .bcd_units(units_min)
  );

  contador_mod_param #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(23)) u_hr (
    .clk(clk), .reset_clk(reset_clk), .en(wrap_min), .up_down(1'b1), .load(1'b0),
    .load_val(5'd0), .conta(conta_hr), .wrap(wrap_hr), .borrow(borrow_hr),
    .bcd_tens(tens_hr), .bcd_units(units_hr)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({conta_a, wrap_a, borrow_a, tens_a, units_a} !== {5'd0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_a: got conta=%0d w=%b b=%b bcd=%0d/%0d want 0 0 0 0/0",
               conta_a, wrap_a, borrow_a, tens_a, units_a);
    end
    checks++;
    if ({conta_b, tens_b, units_b} !== {4'd1, 4'd0, 4'd1}) begin
      errors++;
      $display("FAIL reset_b: got conta=%0d bcd=%0d/%0d want 1 0/1", conta_b, tens_b, units_b);
    end
    reset_clk = 1'b1;
  endtask

  task automatic test_count_wrap();
    logic [4:0] exp_c;
    logic       exp_w;
    en_a = 1'b1;
    ud_a = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      exp_c = (k <= 23) ? 5'(k) : 5'(k - 24);
      exp_w = (k == 24);
      checks++;
      if ({conta_a, wrap_a, borrow_a, tens_a, units_a} !==
          {exp_c, exp_w, 1'b0, 4'(exp_c / 5'd10), 4'(exp_c % 5'd10)}) begin
        errors++;
        $display("FAIL count_up[%0d]: got conta=%0d w=%b b=%b bcd=%0d/%0d want conta=%0d w=%b",
                 k, conta_a, wrap_a, borrow_a, tens_a, units_a, exp_c, exp_w);
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_down_borrow();
    en_b = 1'b1;
    ud_b = 1'b0;
    step();
    en_b = 1'b0;
    checks++;
    if ({conta_b, wrap_b, borrow_b, tens_b, units_b} !== {4'd12, 1'b0, 1'b1, 4'd1, 4'd2}) begin
      errors++;
      $display("FAIL borrow_m12: got conta=%0d w=%b b=%b bcd=%0d/%0d want 12 0 1 1/2",
               conta_b, wrap_b, borrow_b, tens_b, units_b);
    end
    step();
    checks++;
    if ({conta_b, borrow_b} !== {4'd12, 1'b0}) begin
      errors++;
      $display("FAIL borrow_pulse_len: got conta=%0d b=%b want 12 0", conta_b, borrow_b);
    end
    load_b = 1'b1;
    lv_b   = 4'd0;
    step();
    checks++;
    if (conta_b !== 4'd1) begin
      errors++;
      $display("FAIL clamp_low_m12: got %0d want 1", conta_b);
    end
    lv_b = 4'd15;
    step();
    load_b = 1'b0;
    checks++;
    if (conta_b !== 4'd12) begin
      errors++;
      $display("FAIL clamp_high_m12: got %0d want 12", conta_b);
    end
  endtask

  task automatic test_load_clamp();
    load_a = 1'b1;
    lv_a   = 5'd30;
    step();
    checks++;
    if ({conta_a, wrap_a} !== {5'd23, 1'b0}) begin
      errors++;
      $display("FAIL clamp_high: got conta=%0d w=%b want 23 0", conta_a, wrap_a);
    end
    en_a = 1'b1;
    ud_a = 1'b1;
    lv_a = 5'd23;
    step();
    checks++;
    if ({conta_a, wrap_a, borrow_a} !== {5'd23, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_en_at_max: got conta=%0d w=%b b=%b want 23 0 0", conta_a, wrap_a, borrow_a);
    end
    en_a = 1'b0;
    lv_a = 5'd5;
    step();
    load_a = 1'b0;
    checks++;
    if ({conta_a, tens_a, units_a} !== {5'd5, 4'd0, 4'd5}) begin
      errors++;
      $display("FAIL load_in_range: got conta=%0d bcd=%0d/%0d want 5 0/5", conta_a, tens_a, units_a);
    end
  endtask

  task automatic test_hold_priority();
    load_a = 1'b1;
    lv_a   = 5'd17;
    step();
    load_a = 1'b0;
    en_a   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({conta_a, wrap_a, borrow_a, tens_a, units_a} !== {5'd17, 1'b0, 1'b0, 4'd1, 4'd7}) begin
        errors++;
        $display("FAIL hold[%0d]: got conta=%0d w=%b b=%b bcd=%0d/%0d want 17 0 0 1/7",
                 k, conta_a, wrap_a, borrow_a, tens_a, units_a);
      end
    end
    load_a = 1'b1;
    en_a   = 1'b1;
    lv_a   = 5'd4;
    step();
    load_a = 1'b0;
    en_a   = 1'b0;
    checks++;
    if (conta_a !== 5'd4) begin
      errors++;
      $display("FAIL load_over_en: got %0d want 4", conta_a);
    end
  endtask

  task automatic test_down_count();
    en_a = 1'b1;
    ud_a = 1'b0;
    load_a = 1'b1;
    lv_a = 5'd1;
    step();
    load_a = 1'b0;
    step();
    checks++;
    if ({conta_a, borrow_a} !== {5'd0, 1'b0}) begin
      errors++;
      $display("FAIL down_to_min: got conta=%0d b=%b want 0 0", conta_a, borrow_a);
    end
    step();
    checks++;
    if ({conta_a, wrap_a, borrow_a, tens_a, units_a} !== {5'd23, 1'b0, 1'b1, 4'd2, 4'd3}) begin
      errors++;
      $display("FAIL borrow_a: got conta=%0d w=%b b=%b bcd=%0d/%0d want 23 0 1 2/3",
               conta_a, wrap_a, borrow_a, tens_a, units_a);
    end
    step();
    en_a = 1'b0;
    ud_a = 1'b1;
    checks++;
    if ({conta_a, borrow_a} !== {5'd22, 1'b0}) begin
      errors++;
      $display("FAIL down_after_borrow: got conta=%0d b=%b want 22 0", conta_a, borrow_a);
    end
  endtask

  task automatic test_async_reset();
    load_a = 1'b1;
    lv_a   = 5'd15;
    step();
    load_a = 1'b0;
    checks++;
    if (conta_a !== 5'd15) begin
      errors++;
      $display("FAIL preload_15: got %0d want 15", conta_a);
    end
    #2 reset_clk = 1'b0;
    #1;
    checks++;
    if ({conta_a, wrap_a, tens_a, units_a} !== {5'd0, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset: got conta=%0d w=%b bcd=%0d/%0d want 0 0 0/0",
               conta_a, wrap_a, tens_a, units_a);
    end
    @(negedge clk);
    reset_clk = 1'b1;
    en_a = 1'b1;
    ud_a = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (conta_a !== 5'(k)) begin
        errors++;
        $display("FAIL resume[%0d]: got %0d want %0d", k, conta_a, k);
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_cascade();
    int min_wraps = 0;
    int hr_wraps  = 0;
    int both      = 0;
    en_c = 1'b1;
    for (int k = 1; k <= 1441; k++) begin
      if (k == 1441) en_c = 1'b0;
      step();
      if (wrap_min) min_wraps++;
      if (wrap_hr) hr_wraps++;
      if ((wrap_min && borrow_min) || (wrap_hr && borrow_hr)) both++;
      if (k == 61) begin
        checks++;
        if ({conta_min, conta_hr, tens_min, units_min} !== {6'd1, 5'd1, 4'd0, 4'd1}) begin
          errors++;
          $display("FAIL cascade_61: got min=%0d hr=%0d want 1 1", conta_min, conta_hr);
        end
      end
      if (k == 1439) begin
        checks++;
        if ({conta_min, conta_hr, tens_min, units_min, tens_hr, units_hr} !==
            {6'd59, 5'd23, 4'd5, 4'd9, 4'd2, 4'd3}) begin
          errors++;
          $display("FAIL cascade_2359: got min=%0d hr=%0d want 59 23", conta_min, conta_hr);
        end
      end
    end
    checks++;
    if ({conta_min, conta_hr, wrap_hr} !== {6'd0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL cascade_end: got min=%0d hr=%0d hw=%b want 0 0 1", conta_min, conta_hr, wrap_hr);
    end
    checks++;
    if (min_wraps !== 24) begin
      errors++;
      $display("FAIL min_wraps: got %0d want 24", min_wraps);
    end
    checks++;
    if (hr_wraps !== 1) begin
      errors++;
      $display("FAIL hr_wraps: got %0d want 1", hr_wraps);
    end
    checks++;
    if (both !== 0) begin
      errors++;
      $display("FAIL wrap_borrow_overlap: got %0d want 0", both);
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_down_borrow();
    test_load_clamp();
    test_hold_priority();
    test_down_count();
    test_async_reset();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_mod_param.md
Name: contador_mod_param

Overview:
- Parametrised modulo counter for the RTC timekeeping chain; successor of the fixed 0..23 hour counter.
- One instance each covers seconds, minutes, hours, day, month or year via MIN_VAL/MAX_VAL.
- Adds enable, up/down counting, synchronous load with range clamping, wrap/borrow pulses for cascading, and a registered two-digit BCD output for the display path.

Parameters:
- WIDTH, 5, bit width of the count value (MAX_VAL must fit; WIDTH ≤ 7).
- MIN_VAL, 0, lowest count value (1 for day/month counters).
- MAX_VAL, 23, highest count value; requires MAX_VAL > MIN_VAL and MAX_VAL ≤ 99.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_clk  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
- en  input  1  count enable (cascade input from the previous stage's wrap/borrow).
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- conta  output  WIDTH  current count.
- wrap  output  1  one-cycle pulse: up-count wrapped MAX_VAL→MIN_VAL.
- borrow  output  1  one-cycle pulse: down-count wrapped MIN_VAL→MAX_VAL.
- bcd_tens  output  4  tens digit of conta, registered.
- bcd_units  output  4  units digit of conta, registered.

Behaviour:
- Reset (reset_clk=0, asynchronous):
  - conta=MIN_VAL, wrap=0, borrow=0.
  - bcd_tens/bcd_units = BCD of MIN_VAL.
  - Reset held low overrides every other input; release takes effect at the next rising clk.
- Priority per cycle: load > en > hold.
- load=1:
  - conta ← clamp(load_val): load_val<MIN_VAL gives MIN_VAL; load_val>MAX_VAL gives MAX_VAL; otherwise load_val.
  - wrap=borrow=0 that cycle, even if en=1 simultaneously.
- load=0, en=1, up_down=1:
  - conta<MAX_VAL: conta+1, wrap=0.
  - conta==MAX_VAL: conta=MIN_VAL, wrap=1 for exactly that one cycle.
- load=0, en=1, up_down=0:
  - conta>MIN_VAL: conta-1, borrow=0.
  - conta==MIN_VAL: conta=MAX_VAL, borrow=1 for one cycle.
- load=0, en=0: conta holds; wrap=borrow=0.
- wrap and borrow are registered, are never 1 simultaneously, and assert in the same cycle conta shows the wrapped value.
- Held en=1 across several wraps produces one wrap pulse per wrap event; there is no stretching.
- Out-of-range state:
  - If conta ever holds a value outside [MIN_VAL, MAX_VAL], the next enabled count step forces MIN_VAL (up) or MAX_VAL (down), with no wrap/borrow pulse.
  - Load clamps as above.
- Arithmetic: internal compare/increment at WIDTH bits; no overflow past MAX_VAL is possible.
- BCD path:
  - bcd_tens/bcd_units are registered from the next-state count value, so they match conta in the same cycle (zero lag to conta).
  - tens = value/10, units = value%10, both computed by subtract-compare logic; no divider.
- Cascade use: stage N+1 en = stage N wrap (up) or borrow (down); chained stages share clk and reset_clk.

Test Plan:
- Reset and count: reset_clk low 3 cycles, then en=1, up_down=1 for 25 cycles with defaults (0..23):
  - During reset: conta=0, bcd=0/0.
  - conta counts 1..23, then 0 on cycle 24 with wrap=1 for that single cycle.
  - conta=1 on cycle 25, wrap=0.
- Down-count wrap with MIN_VAL=1, MAX_VAL=12, starting from conta=1: en=1, up_down=0 one cycle → conta=12, borrow=1, bcd_tens=1, bcd_units=2.
- Load clamping with defaults:
  - load=1, load_val=30 → conta=23.
  - With MIN_VAL=1: load_val=0 → conta=1.
  - load=1 with en=1, load_val=23 → conta=23, wrap=0.
- Hold and priority: en=0 for 5 cycles at conta=17 → conta stays 17, bcd=1/7, no pulses; then load and en asserted together → load wins.
- Async reset mid-operation: assert reset_clk low between clock edges while conta=15 → conta=0 immediately (before the next edge), wrap=0; after release, counting resumes from 0.
- Cascade: two instances, 0..59 feeding 0..23 via wrap→en; 60×24 enables → minutes wrap 24 times and hours return to 0 with a single wrap pulse.
